// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences PC/IR/RF/ALU/data-memory through IF/DEC/EX/MEM/WB.
// Optional illegal-opcode trap enabled by defining MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      Instr,
  input  logic             Zero,
  input  logic             Mem_Ready,
  output logic             IR_LdEn,
  output logic             PC_LdEn,
  output logic             PC_sel,
  output logic             RF_WrEn,
  output logic             RF_B_sel,
  output logic             RF_WrData_sel,
  output logic             ALU_Bin_sel,
  output logic [3:0]       ALU_func,
  output logic [1:0]       ImmExt_sel,
  output logic             Mem_Req,
  output logic             Mem_WrEn,
  output logic             ByteOp,
  output logic             Halt,
  output logic [CNT_W-1:0] Instr_Count,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_DEC  = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] opc;
  logic is_r, is_li, is_lui, is_addi, is_andi, is_ori;
  logic is_b, is_beq, is_bne, is_lb, is_lw, is_sb, is_sw;
  logic is_imm, is_br, is_load, is_store, is_known;
  logic [3:0] alu_func_dec;
  logic [1:0] imm_sel_dec;

  // Register fields are consumed by the datapath, not by this controller.
  logic unused_instr_bits;
  assign unused_instr_bits = ^Instr[25:4];

  always_comb begin
    opc      = Instr[31:26];
    is_r     = (opc == 6'b100000);
    is_li    = (opc == 6'b111000);
    is_lui   = (opc == 6'b111001);
    is_addi  = (opc == 6'b110000);
    is_andi  = (opc == 6'b110010);
    is_ori   = (opc == 6'b110011);
    is_b     = (opc == 6'b111111);
    is_beq   = (opc == 6'b000000);
    is_bne   = (opc == 6'b000001);
    is_lb    = (opc == 6'b000011);
    is_lw    = (opc == 6'b001111);
    is_sb    = (opc == 6'b000111);
    is_sw    = (opc == 6'b011111);
    is_imm   = is_li | is_lui | is_addi | is_andi | is_ori;
    is_br    = is_b | is_beq | is_bne;
    is_load  = is_lb | is_lw;
    is_store = is_sb | is_sw;
    is_known = is_r | is_imm | is_br | is_load | is_store;

    alu_func_dec = 4'b0000;
    if (is_r)         alu_func_dec = Instr[3:0];
    else if (is_andi) alu_func_dec = 4'b0010;
    else if (is_ori)  alu_func_dec = 4'b0011;
    else if (is_br)   alu_func_dec = 4'b0001;

    imm_sel_dec = 2'b00;
    if (is_andi | is_ori) imm_sel_dec = 2'b01;
    else if (is_lui)      imm_sel_dec = 2'b10;
    else if (is_br)       imm_sel_dec = 2'b11;
  end

  always_comb begin
    state_d       = state_q;
    IR_LdEn       = 1'b0;
    PC_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    RF_WrEn       = 1'b0;
    RF_B_sel      = 1'b0;
    RF_WrData_sel = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = 4'b0000;
    ImmExt_sel    = 2'b00;
    Mem_Req       = 1'b0;
    Mem_WrEn      = 1'b0;
    ByteOp        = 1'b0;
    Halt          = 1'b0;

    case (state_q)
      S_IF: begin
        IR_LdEn = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        RF_B_sel = is_beq | is_bne | is_store;
        if (is_known) state_d = S_EX;
        else begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_WB;
`endif
        end
      end
      S_EX: begin
        ALU_Bin_sel = ~(is_r | is_br);
        ALU_func    = alu_func_dec;
        ImmExt_sel  = imm_sel_dec;
        if (is_br) begin
          PC_LdEn = 1'b1;
          PC_sel  = is_b | (is_beq & Zero) | (is_bne & ~Zero);
          state_d = S_IF;
        end else if (is_load | is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        Mem_Req  = 1'b1;
        Mem_WrEn = is_store;
        ByteOp   = is_lb | is_sb;
        if (Mem_Ready) begin
          if (is_store) begin
            PC_LdEn = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        // Unknown opcodes arrive here only as NOPs: retire without writing.
        RF_WrEn       = is_known;
        RF_WrData_sel = is_load;
        PC_LdEn       = 1'b1;
        state_d       = S_IF;
      end
      S_HALT: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        Halt    = 1'b1;
        state_d = S_HALT;
`else
        state_d = S_IF;
`endif
      end
      default: state_d = S_IF;
    endcase

    // Reset dominates everything, including an in-flight memory access.
    if (!Reset) begin
      state_d       = S_IF;
      IR_LdEn       = 1'b0;
      PC_LdEn       = 1'b0;
      PC_sel        = 1'b0;
      RF_WrEn       = 1'b0;
      RF_B_sel      = 1'b0;
      RF_WrData_sel = 1'b0;
      ALU_Bin_sel   = 1'b0;
      ALU_func      = 4'b0000;
      ImmExt_sel    = 2'b00;
      Mem_Req       = 1'b0;
      Mem_WrEn      = 1'b0;
      ByteOp        = 1'b0;
      Halt          = 1'b0;
    end
  end

  always_comb begin
    if (!Reset) cnt_d = '0;
    else        cnt_d = cnt_q + CNT_W'(PC_LdEn);
  end

  always_ff @(posedge Clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign Instr_Count = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction phase model feeds an expected queue
// checked every cycle on the falling edge; a narrow counter width exercises wraparound.
module tb_multicycle_ctrl;

  localparam int CW = 4;
  localparam int W  = 17 + CW;
  localparam int B_IR = 16, B_PCL = 15, B_PCS = 14, B_RFW = 13, B_RFB = 12;
  localparam int B_WDS = 11, B_ABS = 10, B_MR = 3, B_MW = 2, B_BO = 1, B_H = 0;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic [31:0]   Instr = '0;
  logic          Zero = 1'b0;
  logic          Mem_Ready = 1'b0;
  logic          IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_B_sel, RF_WrData_sel;
  logic          ALU_Bin_sel, Mem_Req, Mem_WrEn, ByteOp, Halt;
  logic [3:0]    ALU_func;
  logic [1:0]    ImmExt_sel;
  logic [CW-1:0] Instr_Count;
  logic [2:0]    dbg_state;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .IR_LdEn(IR_LdEn), .PC_LdEn(PC_LdEn), .PC_sel(PC_sel), .RF_WrEn(RF_WrEn),
    .RF_B_sel(RF_B_sel), .RF_WrData_sel(RF_WrData_sel), .ALU_Bin_sel(ALU_Bin_sel),
    .ALU_func(ALU_func), .ImmExt_sel(ImmExt_sel), .Mem_Req(Mem_Req), .Mem_WrEn(Mem_WrEn),
    .ByteOp(ByteOp), .Halt(Halt), .Instr_Count(Instr_Count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  int            total = 0;
  int            bad   = 0;
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] model_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // scoreboard: every pushed cycle is checked on the falling edge
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("cycle", 64'({Instr_Count, IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_B_sel,
                          RF_WrData_sel, ALU_Bin_sel, ALU_func, ImmExt_sel, Mem_Req,
                          Mem_WrEn, ByteOp, Halt}), 64'(e));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [16:0] ctl);
    exp_q.push_back({model_cnt, ctl});
    if (ctl[B_PCL]) model_cnt = model_cnt + 1'b1;
  endtask

  // kind: 0 R-type, 1 immediate, 2 branch, 3 load, 4 store, 5 unknown
  task automatic spec_info(input logic [5:0] op, input logic [3:0] fn, output int kind,
                           output logic [3:0] af, output logic [1:0] ims,
                           output logic rtsel, output logic byte_acc);
    kind = 5; af = 4'b0000; ims = 2'b00; rtsel = 1'b0; byte_acc = 1'b0;
    case (op)
      6'b100000: begin kind = 0; af = fn; end
      6'b111000, 6'b110000: kind = 1;
      6'b111001: begin kind = 1; ims = 2'b10; end
      6'b110010: begin kind = 1; af = 4'b0010; ims = 2'b01; end
      6'b110011: begin kind = 1; af = 4'b0011; ims = 2'b01; end
      6'b111111: begin kind = 2; af = 4'b0001; ims = 2'b11; end
      6'b000000, 6'b000001: begin kind = 2; af = 4'b0001; ims = 2'b11; rtsel = 1'b1; end
      6'b000011: begin kind = 3; byte_acc = 1'b1; end
      6'b001111: kind = 3;
      6'b000111: begin kind = 4; byte_acc = 1'b1; rtsel = 1'b1; end
      6'b011111: begin kind = 4; rtsel = 1'b1; end
      default: kind = 5;
    endcase
  endtask

  // driver: one instruction from IF entry; abort_at>=0 pulls reset in that MEM wait cycle
  task automatic do_instr(input logic [5:0] op, input logic [3:0] fn, input logic z,
                          input int waits, input int abort_at, input int cnt_lit,
                          input int cyc_lit);
    int kind, cycles;
    logic [3:0] af;
    logic [1:0] ims;
    logic rtsel, byte_acc, taken, halted;
    logic [16:0] e;
    spec_info(op, fn, kind, af, ims, rtsel, byte_acc);
    halted = 1'b0;
    cycles = 0;

    tick();
    Reset = 1'b1; Instr = {op, 22'h2A5C3, fn}; Zero = z; Mem_Ready = 1'b0;
    if (cnt_lit >= 0) check("count_literal", 64'(Instr_Count), 64'(cnt_lit));
    e = '0; e[B_IR] = 1'b1; push(e); cycles++;

    tick();
    e = '0; e[B_RFB] = rtsel; push(e); cycles++;

    if (kind == 5) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      halted = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick(); e = '0; e[B_H] = 1'b1; push(e);
      end
      tick(); Reset = 1'b0; push('0); model_cnt = '0;
`else
      tick(); e = '0; e[B_PCL] = 1'b1; push(e); cycles++;
`endif
    end else begin
      tick();
      e = '0;
      e[B_ABS] = (kind == 1 || kind == 3 || kind == 4);
      e[9:6] = af; e[5:4] = ims;
      if (kind == 2) begin
        taken = (op == 6'b111111) || (op == 6'b000000 && z) || (op == 6'b000001 && !z);
        e[B_PCL] = 1'b1; e[B_PCS] = taken;
      end
      push(e); cycles++;

      if (kind == 3 || kind == 4) begin
        for (int i = 0; i < waits && !halted; i++) begin
          tick();
          if (i == abort_at) begin
            Reset = 1'b0; push('0); model_cnt = '0; halted = 1'b1;
          end else begin
            e = '0; e[B_MR] = 1'b1; e[B_MW] = (kind == 4); e[B_BO] = byte_acc;
            push(e); cycles++;
          end
        end
        if (!halted) begin
          tick(); Mem_Ready = 1'b1;
          e = '0; e[B_MR] = 1'b1; e[B_MW] = (kind == 4); e[B_BO] = byte_acc;
          e[B_PCL] = (kind == 4);
          push(e); cycles++;
        end
      end

      if (!halted && kind != 2 && kind != 4) begin
        tick(); Mem_Ready = 1'b0;
        e = '0; e[B_RFW] = 1'b1; e[B_WDS] = (kind == 3); e[B_PCL] = 1'b1;
        push(e); cycles++;
      end
    end
    if (cyc_lit >= 0 && !halted) check("latency", 64'(cycles), 64'(cyc_lit));
  endtask

  initial begin
    // two reset cycles: outputs forced low, count cleared, state IF
    tick(); push('0);
    check("reset_state", 64'(dbg_state), 64'd0);
    tick(); push('0);
    check("reset_count", 64'(Instr_Count), 64'd0);

    do_instr(6'b100000, 4'b0000, 1'b0, 0, -1, -1, 4);   // add
    do_instr(6'b001111, 4'b0000, 1'b0, 3, -1, 1, 8);    // lw, 3 wait cycles
    do_instr(6'b000000, 4'b0000, 1'b1, 0, -1, 2, 3);    // beq taken
    do_instr(6'b000001, 4'b0000, 1'b1, 0, -1, -1, 3);   // bne not taken
    do_instr(6'b000000, 4'b0000, 1'b0, 0, -1, -1, 3);   // beq not taken
    do_instr(6'b000001, 4'b0000, 1'b0, 0, -1, -1, 3);   // bne taken
    do_instr(6'b111111, 4'b0000, 1'b0, 0, -1, -1, 3);   // b
    do_instr(6'b110000, 4'b1111, 1'b0, 0, -1, -1, 4);   // addi
    do_instr(6'b111000, 4'b0101, 1'b0, 0, -1, -1, 4);   // li
    do_instr(6'b111001, 4'b0000, 1'b0, 0, -1, -1, 4);   // lui
    do_instr(6'b110010, 4'b0000, 1'b0, 0, -1, -1, 4);   // andi
    do_instr(6'b110011, 4'b0000, 1'b0, 0, -1, -1, 4);   // ori
    do_instr(6'b000011, 4'b0000, 1'b0, 0, -1, -1, 5);   // lb, ready with request
    do_instr(6'b000111, 4'b0000, 1'b0, 1, -1, -1, 5);   // sb, one wait
    do_instr(6'b011111, 4'b0000, 1'b0, 0, -1, 14, 4);   // sw
    do_instr(6'b101010, 4'b0000, 1'b0, 0, -1, 15, 3);   // unknown opcode
    do_instr(6'b011111, 4'b0000, 1'b0, 5, 2, -1, -1);   // sw aborted by reset
    for (int i = 0; i < 18; i++)                         // count wraps at 16
      do_instr(6'b100000, 4'(i), 1'b0, 0, -1, (i == 0 || i == 16) ? 0 : -1, 4);

    @(negedge Clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
